mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Single-port arbiter and sequencer for the 16-bit external SRAM. It shares the SRAM between the core's memory stage and the JTAG debug port.
- Each requester uses a req/ack handshake.
- The arbiter registers the SRAM address and controls, and owns the SRAM data bus.
- It captures read data and returns a one-cycle ack to the winner.
- It sits between the core/debug logic and the processor's io_mem* pins.

Parameters:
ADDR_W, 16, SRAM word-address width
DATA_W, 16, SRAM data width
STARVE_LIMIT, 4, consecutive debug grants allowed while core waits (used only with MEM_ARB_STARVE_EN)

Ports:
i_clk  in  1  processor clock
i_rstn  in  1  reset; one clock; reset is synchronous and active-low
i_coreReq  in  1  core access request, held until o_coreAck
i_coreWr  in  1  core access is write (1) / read (0)
i_coreAddr  in  ADDR_W  core word address
i_coreWdata  in  DATA_W  core write data
o_coreAck  out  1  one-cycle completion pulse to core
o_coreRdata  out  DATA_W  read data, valid while o_coreAck=1
i_dbgReq  in  1  debug (JTAG) access request, held until o_dbgAck
i_dbgWr  in  1  debug write/read
i_dbgAddr  in  ADDR_W  debug word address
i_dbgWdata  in  DATA_W  debug write data
o_dbgAck  out  1  one-cycle completion pulse to debug
o_dbgRdata  out  DATA_W  read data, valid while o_dbgAck=1
o_memAddr  out  ADDR_W  registered SRAM address
io_memData  inout  DATA_W  SRAM data bus
o_memWr  out  1  registered SRAM write strobe
o_memEn  out  1  registered SRAM enable
o_busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: bus released, o_memEn=0.
  - ACCESS: exactly one cycle; o_memEn=1, address and controls stable.
  - ACK: exactly one cycle; winner's ack=1.
  - Transition order is IDLE -> ACCESS -> ACK -> IDLE.
- Requester rules:
  - Address, wr and wdata must stay stable from req rise until ack.
  - req is not sampled in ACCESS or ACK, so a requester that deasserts req in the cycle after ack is never double-served.
- IDLE, at the edge where a req is seen:
  - Pick the winner by priority.
  - Register the winner's addr/wr into o_memAddr/o_memWr, set o_memEn=1, latch the winner ID and wdata, go to ACCESS.
  - Priority: debug over core when both requests are high in the same cycle.
- ACCESS:
  - io_memData = latched wdata when o_memWr=1, otherwise high-Z.
  - At the closing edge: capture io_memData into the shared rdata register (reads only; rdata holds its value on writes), clear o_memEn/o_memWr, assert the winner's ack, go to ACK.
- ACK: both o_coreRdata and o_dbgRdata show the rdata register; only the winner's ack is high. Next state is IDLE.
- Latency: req sampled at edge 0, SRAM access in cycle 1, ack in cycle 2, next grant possible at edge 3. Maximum throughput is one access per 3 cycles.
- The loser keeps req asserted and is served on the next IDLE evaluation. No request is dropped.
- Reset (i_rstn=0 at a clock edge), including mid-ACCESS or mid-ACK:
  - Next state is IDLE.
  - o_memEn=0, o_memWr=0, o_memAddr=0, both acks 0, rdata=0, io_memData high-Z.
  - The in-flight access is aborted with no ack. Requesters must re-request after reset.
- The arbiter never drives io_memData outside ACCESS with a write.

Optional Feature:
MEM_ARB_STARVE_EN
- Defined: a starvation counter protects the core.
  - The counter increments on each debug grant made while i_coreReq=1.
  - It clears on any core grant, or when i_coreReq=0 in IDLE.
  - When the count equals STARVE_LIMIT, the next IDLE grant goes to the core even if i_dbgReq=1.
  - The counter resets to 0.
- Undefined: strict debug priority, no counter logic. The core can be starved indefinitely by continuous debug traffic.

Test Plan:
- Reset then core write: addr 0x0012, wdata 0xBEEF, wr=1 -> o_memEn=1/o_memWr=1/o_memAddr=0x0012/io_memData=0xBEEF in cycle 1; o_coreAck pulse in cycle 2; io_memData high-Z otherwise.
- Core read: addr 0x0012, SRAM model returns 0xBEEF -> o_coreAck in cycle 2 with o_coreRdata=0xBEEF; o_dbgAck stays 0.
- Simultaneous core and debug requests -> debug served first (o_dbgAck at cycle 2); core o_memEn at cycle 4; o_coreAck at cycle 5; each ack is exactly one cycle.
- Debug req held continuously, core req high, MEM_ARB_STARVE_EN defined with STARVE_LIMIT=4 -> 4 debug acks, then a core ack, then debug resumes. Without the macro, no core ack occurs over 50 cycles.
- i_rstn driven low during ACCESS of a write -> next edge: o_memEn=0, o_memWr=0, no ack, o_busy=0, bus high-Z. After release, a new req is served normally.
- Requester drops req the cycle after ack while the other requester is idle -> no second ACCESS; arbiter remains IDLE and o_busy=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter/sequencer shared by the core memory stage and the JTAG debug port.
// Optional core starvation guard: define MEM_ARB_STARVE_EN (limit set by STARVE_LIMIT).
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_coreReq,
  input  logic              i_coreWr,
  input  logic [ADDR_W-1:0] i_coreAddr,
  input  logic [DATA_W-1:0] i_coreWdata,
  output logic              o_coreAck,
  output logic [DATA_W-1:0] o_coreRdata,
  input  logic              i_dbgReq,
  input  logic              i_dbgWr,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  input  logic [DATA_W-1:0] i_dbgWdata,
  output logic              o_dbgAck,
  output logic [DATA_W-1:0] o_dbgRdata,
  output logic [ADDR_W-1:0] o_memAddr,
  inout  logic [DATA_W-1:0] io_memData,
  output logic              o_memWr,
  output logic              o_memEn,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t            state, state_nxt;
  logic              grant, grant_dbg;
  logic              starve_hit;
  logic              win_dbg;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Requests are only looked at in IDLE, so a requester dropping req after its ack is never re-served.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dbg = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_dbgReq || i_coreReq) begin
          grant     = 1'b1;
          grant_dbg = i_dbgReq && !(starve_hit && i_coreReq);
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      win_dbg    <= 1'b0;
    end else begin
      if (grant) begin
        mem_addr_q <= grant_dbg ? i_dbgAddr   : i_coreAddr;
        mem_wr_q   <= grant_dbg ? i_dbgWr     : i_coreWr;
        wdata_q    <= grant_dbg ? i_dbgWdata  : i_coreWdata;
        win_dbg    <= grant_dbg;
      end
      if (state == ACCESS) begin
        if (!mem_wr_q) rdata_q <= io_memData;
        mem_wr_q <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts debug grants taken while the core is waiting; any core grant or idle core clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_coreReq || (grant && !grant_dbg)) starve_cnt <= '0;
      else if (grant_dbg)                      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    o_memEn   = (state == ACCESS);
    o_busy    = (state != IDLE);
    o_coreAck = (state == ACK) && !win_dbg;
    o_dbgAck  = (state == ACK) &&  win_dbg;
  end

  assign o_memAddr   = mem_addr_q;
  assign o_memWr     = mem_wr_q;
  assign o_coreRdata = rdata_q;
  assign o_dbgRdata  = rdata_q;
  assign io_memData  = (state == ACCESS && mem_wr_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed protocol cases plus randomized two-requester traffic.
// Core uses word addresses 0..31 (plus 0xFF for the aborted write), debug uses 32..63.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        core_req, core_wr, dbg_req, dbg_wr;
  logic [15:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        o_coreAck, o_dbgAck, o_memWr, o_memEn, o_busy;
  logic [15:0] o_coreRdata, o_dbgRdata, o_memAddr;
  tri1  [15:0] mem_data;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_coreReq(core_req), .i_coreWr(core_wr), .i_coreAddr(core_addr), .i_coreWdata(core_wdata),
    .o_coreAck(o_coreAck), .o_coreRdata(o_coreRdata),
    .i_dbgReq(dbg_req), .i_dbgWr(dbg_wr), .i_dbgAddr(dbg_addr), .i_dbgWdata(dbg_wdata),
    .o_dbgAck(o_dbgAck), .o_dbgRdata(o_dbgRdata),
    .o_memAddr(o_memAddr), .io_memData(mem_data), .o_memWr(o_memWr), .o_memEn(o_memEn),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] init_val(input int unsigned a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  // SRAM model: drives the bus only for enabled reads; the pull-up shows a released bus as 0xFFFF.
  logic [15:0] sram [0:255];
  assign mem_data = (o_memEn && !o_memWr) ? sram[o_memAddr[7:0]] : 16'hzzzz;

  initial begin
    for (int unsigned a = 0; a < 256; a++) sram[a] = init_val(a);
    forever begin
      @(posedge i_clk);
      if (o_memEn && o_memWr) sram[o_memAddr[7:0]] = mem_data;
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } xact_t;

  xact_t       core_q[$];
  xact_t       dbg_q[$];
  int unsigned core_rd, dbg_rd;
  logic [15:0] ref_mem [0:255];
  int          vectors, miscompares;
  bit          mon_en;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic xact_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    xact_t e;
    e.addr  = addr;
    e.wr    = wr;
    e.wdata = wdata;
    e.rdata = ref_mem[addr[7:0]];
    if (wr) ref_mem[addr[7:0]] = wdata;
    return e;
  endfunction

  // Both tasks start #1 after a posedge and return #1 after the posedge that ends the ack cycle.
  task automatic core_xact(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat);
    bit done = 0;
    core_q.push_back(mk(wr, addr, wdata));
    core_wr = wr; core_addr = addr; core_wdata = wdata; core_req = 1'b1;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge i_clk); lat++;
      @(negedge i_clk); if (o_coreAck) done = 1;
    end
    if (!done) chk("core_ack_timeout", 16'd0, 16'd1);
    @(posedge i_clk); #1 core_req = 1'b0;
  endtask

  task automatic dbg_xact(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat);
    bit done = 0;
    dbg_q.push_back(mk(wr, addr, wdata));
    dbg_wr = wr; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge i_clk); lat++;
      @(negedge i_clk); if (o_dbgAck) done = 1;
    end
    if (!done) chk("dbg_ack_timeout", 16'd0, 16'd1);
    @(posedge i_clk); #1 dbg_req = 1'b0;
  endtask

  initial begin
    int          lat, dbg_at, core_at, n_core, n_dbg;
    logic [8:0]  en_mask;
    bit          drop_core, drop_dbg;
    bit          ack_seq[$];
    logic [15:0] acc_addr, acc_data;
    logic        acc_wr, core_prev, dbg_prev;
    xact_t       e;

    vectors = 0; miscompares = 0; mon_en = 0; core_rd = 0; dbg_rd = 0;
    for (int unsigned a = 0; a < 256; a++) ref_mem[a] = init_val(a);
    i_rstn = 1'b0; core_req = 0; dbg_req = 0; core_wr = 0; dbg_wr = 0;
    core_addr = '0; dbg_addr = '0; core_wdata = '0; dbg_wdata = '0;

    fork
      forever begin
        @(negedge i_clk);
        if (mon_en) begin
          if (o_memEn) begin
            acc_addr = o_memAddr; acc_wr = o_memWr; acc_data = mem_data;
          end else begin
            chk("bus_released", mem_data, 16'hFFFF);
          end
          if (o_coreAck && o_dbgAck) chk("dual_ack", 16'd1, 16'd0);
          if (o_coreAck) begin
            chk("core_ack_width", 16'(core_prev), 16'd0);
            if (core_rd < core_q.size()) begin
              e = core_q[core_rd]; core_rd++;
              chk("core_addr", acc_addr, e.addr);
              chk("core_wr", 16'(acc_wr), 16'(e.wr));
              if (e.wr) chk("core_wdata", acc_data, e.wdata);
              else      chk("core_rdata", o_coreRdata, e.rdata);
            end else chk("core_spurious_ack", 16'd1, 16'd0);
          end
          if (o_dbgAck) begin
            chk("dbg_ack_width", 16'(dbg_prev), 16'd0);
            if (dbg_rd < dbg_q.size()) begin
              e = dbg_q[dbg_rd]; dbg_rd++;
              chk("dbg_addr", acc_addr, e.addr);
              chk("dbg_wr", 16'(acc_wr), 16'(e.wr));
              if (e.wr) chk("dbg_wdata", acc_data, e.wdata);
              else      chk("dbg_rdata", o_dbgRdata, e.rdata);
            end else chk("dbg_spurious_ack", 16'd1, 16'd0);
          end
        end
        core_prev = o_coreAck; dbg_prev = o_dbgAck;
      end
    join_none

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", 16'(o_busy), 16'd0);
    chk("rst_memEn", 16'(o_memEn), 16'd0);
    chk("rst_memWr", 16'(o_memWr), 16'd0);
    chk("rst_memAddr", o_memAddr, 16'h0000);
    chk("rst_acks", 16'({o_coreAck, o_dbgAck}), 16'd0);
    chk("rst_coreRdata", o_coreRdata, 16'h0000);
    chk("rst_dbgRdata", o_dbgRdata, 16'h0000);
    chk("rst_bus", mem_data, 16'hFFFF);
    i_rstn = 1'b1;
    mon_en = 1;
    @(posedge i_clk); #1;

    // Core write then read back, then no re-service after req drops
    core_xact(1'b1, 16'h0012, 16'hBEEF, lat);
    chk("core_wr_latency", 16'(lat), 16'd2);
    core_xact(1'b0, 16'h0012, 16'h0000, lat);
    chk("core_rd_latency", 16'(lat), 16'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("idle_busy", 16'(o_busy), 16'd0);
      chk("idle_memEn", 16'(o_memEn), 16'd0);
    end
    @(posedge i_clk); #1;

    // Simultaneous requests: debug first, core three cycles later
    dbg_q.push_back(mk(1'b1, 16'h0021, 16'h5A01));
    core_q.push_back(mk(1'b0, 16'h0012, 16'h0000));
    dbg_wr = 1; dbg_addr = 16'h0021; dbg_wdata = 16'h5A01;
    core_wr = 0; core_addr = 16'h0012;
    dbg_req = 1; core_req = 1;
    dbg_at = -1; core_at = -1; n_core = 0; n_dbg = 0; en_mask = '0; drop_core = 0; drop_dbg = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge i_clk); #1;
      if (drop_dbg) dbg_req = 0;
      if (drop_core) core_req = 0;
      @(negedge i_clk);
      en_mask[k] = o_memEn;
      if (o_dbgAck) begin dbg_at = k; n_dbg++; drop_dbg = 1; end
      if (o_coreAck) begin core_at = k; n_core++; drop_core = 1; end
    end
    chk("prio_dbg_ack_cycle", 16'(dbg_at), 16'd1);
    chk("prio_core_ack_cycle", 16'(core_at), 16'd4);
    chk("prio_memEn_cycles", 16'(en_mask), 16'h0009);
    chk("prio_ack_counts", 16'({n_dbg[7:0], n_core[7:0]}), 16'h0101);
    @(posedge i_clk); #1;

    // Continuous debug traffic with a waiting core
    mon_en = 0;
    dbg_wr = 0; dbg_addr = 16'h0020; core_wr = 0; core_addr = 16'h0001;
    dbg_req = 1; core_req = 1; drop_core = 0; n_core = 0; n_dbg = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge i_clk); #1;
      if (drop_core) core_req = 0;
      @(negedge i_clk);
      if (o_dbgAck) begin ack_seq.push_back(1'b1); n_dbg++; end
      if (o_coreAck) begin ack_seq.push_back(1'b0); n_core++; drop_core = 1; end
    end
`ifdef MEM_ARB_STARVE_EN
    chk("starve_core_acks", 16'(n_core), 16'd1);
    if (ack_seq.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("starve_seq_%0d", i), 16'(ack_seq[i]), (i == 4) ? 16'd0 : 16'd1);
    end else chk("starve_seq_len", 16'(ack_seq.size()), 16'd6);
`else
    chk("starve_core_acks", 16'(n_core), 16'd0);
    chk("starve_dbg_acks", 16'(n_dbg), 16'd17);
`endif
    core_req = 0;
    for (int i = 0; i < 8 && !o_dbgAck; i++) @(negedge i_clk);
    chk("starve_end_ack", 16'(o_dbgAck), 16'd1);
    @(posedge i_clk); #1 dbg_req = 0;
    repeat (3) @(negedge i_clk);
    chk("starve_end_busy", 16'(o_busy), 16'd0);
    @(posedge i_clk); #1;
    mon_en = 1;

    // Reset during the ACCESS cycle of a write aborts it without an ack
    core_wr = 1; core_addr = 16'h00FF; core_wdata = 16'h1234; core_req = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("abort_memEn", 16'(o_memEn), 16'd1);
    chk("abort_memWr", 16'(o_memWr), 16'd1);
    chk("abort_bus_drive", mem_data, 16'h1234);
    i_rstn = 0; core_req = 0;
    @(posedge i_clk); #1;
    chk("abort_memEn_clr", 16'(o_memEn), 16'd0);
    chk("abort_memWr_clr", 16'(o_memWr), 16'd0);
    chk("abort_acks", 16'({o_coreAck, o_dbgAck}), 16'd0);
    chk("abort_busy", 16'(o_busy), 16'd0);
    chk("abort_bus", mem_data, 16'hFFFF);
    i_rstn = 1;
    @(posedge i_clk); #1;
    core_xact(1'b0, 16'h0012, 16'h0000, lat);
    chk("post_rst_latency", 16'(lat), 16'd2);

    // Randomized concurrent traffic
    fork
      begin
        int lc;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
          core_xact(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom), lc);
        end
      end
      begin
        int ld;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(1, 4)) begin @(posedge i_clk); #1; end
          dbg_xact(1'($urandom_range(0, 1)), 16'($urandom_range(32, 63)), 16'($urandom), ld);
        end
      end
    join
    repeat (4) @(posedge i_clk);
    chk("core_q_drained", 16'(core_rd), 16'(core_q.size()));
    chk("dbg_q_drained", 16'(dbg_rd), 16'(dbg_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
